// File: rtl/arb_rr8_if.sv
// rtl/arb_rr8_if.sv - request/grant bundle between requesters and arb_rr8
interface arb_rr8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/arb_rr8.sv
// rtl/arb_rr8.sv - 8-way round-robin arbiter, grant held until done or request drop
// Define ARB_RR8_TIMEOUT_EN to force-revoke grants held for TIMEOUT cycles.
module arb_rr8 #(
  parameter int TIMEOUT = 16
) (
  input logic      clk,
  input logic      rst,
  arb_rr8_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("arb_rr8: TIMEOUT must be within 2..255");
  end

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] grant_idx_q, grant_idx_d;
  logic [2:0] pick_idx;
  logic       pick_found;
  logic       release_c;

`ifdef ARB_RR8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    for (int i = 0; i < 8; i++) begin
      if (!pick_found && bus.req[ptr_q + 3'(i)]) begin
        pick_found = 1'b1;
        pick_idx   = ptr_q + 3'(i);
      end
    end
  end

  assign release_c = bus.done || !bus.req[grant_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      grant_idx_q <= 3'd0;
`ifdef ARB_RR8_TIMEOUT_EN
      hold_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
`ifdef ARB_RR8_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
`ifdef ARB_RR8_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = GRANT;
          grant_idx_d = pick_idx;
`ifdef ARB_RR8_TIMEOUT_EN
          hold_cnt_d  = 8'd0;
`endif
        end
      end
      GRANT: begin
        // A real release always wins over expiry, so timeout never pulses with done.
        if (release_c) begin
          state_d = IDLE;
          ptr_d   = grant_idx_q + 3'd1;
`ifdef ARB_RR8_TIMEOUT_EN
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          ptr_d     = grant_idx_q + 3'd1;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant_valid = (state_q == GRANT);
    bus.grant_idx   = grant_idx_q;
    bus.grant       = (state_q == GRANT) ? (8'd1 << grant_idx_q) : 8'h00;
`ifdef ARB_RR8_TIMEOUT_EN
    bus.timeout     = timeout_q;
`else
    bus.timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_arb_rr8.sv
// tb/tb_arb_rr8.sv - directed table, corner sequences and random run against a model
module tb_arb_rr8;
  localparam int TMO = 4;
`ifdef ARB_RR8_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_rr8_if bus();
  arb_rr8 #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  int m_owner = -1;
  int m_prio  = 0;
  int m_held  = 0;
  bit m_tmo   = 1'b0;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] exp_grant;
    logic       exp_valid;
    logic [2:0] exp_idx;
    logic       exp_tmo;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Owner keeps the resource until it lets go; next search starts just past it.
  task automatic model_step(input bit r, input logic [7:0] q, input bit d);
    bit rel;
    bit expired;
    if (r) begin
      m_owner = -1; m_prio = 0; m_held = 0; m_tmo = 1'b0;
    end else if (m_owner < 0) begin
      m_tmo = 1'b0;
      if (q != 8'h00) begin
        for (int k = 7; k >= 0; k--)
          if (q[(m_prio + k) % 8]) m_owner = (m_prio + k) % 8;
        m_held = 0;
      end
    end else begin
      rel     = d || !q[m_owner];
      expired = TMO_EN && (m_held + 1 >= TMO);
      m_tmo   = 1'b0;
      if (rel || expired) begin
        m_tmo   = !rel;
        m_prio  = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic step(input bit r, input logic [7:0] q, input bit d);
    rst      = r;
    bus.req  = q;
    bus.done = d;
    @(posedge clk);
    model_step(r, q, d);
    @(negedge clk);
  endtask

  task automatic check_invariants();
    check("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
    check("decode", 32'(bus.grant), bus.grant_valid ? 32'(8'd1 << bus.grant_idx) : 32'd0);
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
    check({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    check({tag, ".valid"}, 32'(bus.grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) check({tag, ".idx"}, 32'(bus.grant_idx), 32'(m_owner));
    check({tag, ".timeout"}, 32'(bus.timeout), 32'(m_tmo));
    check_invariants();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rq;
    bit         rr;
    bit         dd;

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'h81, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[3]  = '{1'b0, 8'h81, 1'b0, 8'h80, 1'b1, 3'd7, 1'b0};
    vecs[4]  = '{1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 8'h81, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[8]  = '{1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[9]  = '{1'b0, 8'h0C, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0};
    vecs[10] = '{1'b0, 8'h08, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 8'h10, 1'b0, 8'h10, 1'b1, 3'd4, 1'b0};
    vecs[12] = '{1'b0, 8'h10, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[13] = '{1'b0, 8'h3F, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0};
    vecs[14] = '{1'b0, 8'h3F, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 8'h3F, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 8'h3F, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[17] = '{1'b0, 8'h10, 1'b0, 8'h10, 1'b1, 3'd4, 1'b0};
    vecs[18] = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[19] = '{1'b0, 8'hFF, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
    vecs[20] = '{1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0};
    vecs[21] = '{1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

    rst = 1'b1; bus.req = 8'h00; bus.done = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 22; v++) begin
      step(vecs[v].rst, vecs[v].req, vecs[v].done);
      check($sformatf("vec%0d.grant", v), 32'(bus.grant), 32'(vecs[v].exp_grant));
      check($sformatf("vec%0d.valid", v), 32'(bus.grant_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid)
        check($sformatf("vec%0d.idx", v), 32'(bus.grant_idx), 32'(vecs[v].exp_idx));
      check($sformatf("vec%0d.timeout", v), 32'(bus.timeout), 32'(vecs[v].exp_tmo));
      check_invariants();
    end

`ifdef ARB_RR8_TIMEOUT_EN
    step(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < TMO; c++) begin
      step(1'b0, 8'h02, 1'b0);
      check($sformatf("tmo_hold%0d.grant", c), 32'(bus.grant), 32'h02);
      check($sformatf("tmo_hold%0d.timeout", c), 32'(bus.timeout), 32'd0);
    end
    step(1'b0, 8'h02, 1'b0);
    check("tmo_expire.valid", 32'(bus.grant_valid), 32'd0);
    check("tmo_expire.timeout", 32'(bus.timeout), 32'd1);
    step(1'b0, 8'h02, 1'b0);
    check("tmo_regrant.grant", 32'(bus.grant), 32'h02);
    check("tmo_regrant.timeout", 32'(bus.timeout), 32'd0);
    for (int c = 1; c < TMO; c++) step(1'b0, 8'h02, 1'b0);
    step(1'b0, 8'h02, 1'b1);
    check("tmo_done_same.valid", 32'(bus.grant_valid), 32'd0);
    check("tmo_done_same.timeout", 32'(bus.timeout), 32'd0);
`else
    step(1'b1, 8'h00, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h02, 1'b0);
      check($sformatf("hold%0d.grant", c), 32'(bus.grant), 32'h02);
      check($sformatf("hold%0d.timeout", c), 32'(bus.timeout), 32'd0);
    end
`endif

    step(1'b1, 8'h00, 1'b0);
    rq = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) rq = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, 7)] = ~rq[$urandom_range(0, 7)];
      dd = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 127) == 0);
      step(rr, rq, dd);
      check_model($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
